// File: rtl/fp32_abs_max_stream.sv
// fp32_abs_max_stream
// Streams fp32 frames in and reports, once per frame, the element with the
// largest magnitude (sign bit ignored, bits [30:0] compared as unsigned),
// together with its zero-based position and a frame-length overflow flag.
// Ties keep the earlier element.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_valid/s_ready     input element handshake
//   s_data, s_last      fp32 element, last-of-frame marker
//   m_valid/m_ready     frame result handshake
//   m_data              original fp32 word of the winning element
//   m_idx               position of m_data within the frame (mod 2^IDX_W)
//   m_ovf               frame was longer than 2^IDX_W elements
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no element of the current frame accepted yet
// ACCUM   | at least one element accepted, last not yet seen
// HOLD    | result presented on m_*, waiting for m_ready
module fp32_abs_max_stream #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [IDX_W-1:0] m_idx,
  output logic             m_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  // Goes high on the first edge after reset release; keeps s_ready low
  // while reset is asserted even though the FSM already sits in IDLE.
  logic             live_q;

  logic [31:0]      best_q;
  logic [31:0]      best_d;
  logic [IDX_W-1:0] best_idx_q;
  logic [IDX_W-1:0] best_idx_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             in_fire;
  logic             out_fire;
  logic             better;
  logic             load_out;

  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;
  assign better   = s_data[30:0] > best_q[30:0];
  assign load_out = in_fire & s_last;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          state_d = s_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_fire && s_last) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      ST_IDLE:  s_ready = live_q;
      ST_ACCUM: s_ready = live_q;
      ST_HOLD:  m_valid = 1'b1;
      default: begin
        s_ready = 1'b0;
        m_valid = 1'b0;
      end
    endcase
  end

  // Running best / counter / overflow. The *_d values already include the
  // element being accepted, so the result register can load them directly
  // on the last transfer and m_valid follows one cycle later.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          best_d     = s_data;
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          ovf_d      = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (in_fire) begin
          if (better) begin
            best_d     = s_data;
            best_idx_d = cnt_q;
          end
          // Counter back at zero means 2^IDX_W elements are already in.
          if (cnt_q == '0) begin
            ovf_d = 1'b1;
          end
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Result registers only change on entry to HOLD, so they stay put
  // through HOLD backpressure and keep the previous result in IDLE/ACCUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= '0;
      m_idx  <= '0;
      m_ovf  <= 1'b0;
    end else if (load_out) begin
      m_data <= best_d;
      m_idx  <= best_idx_d;
      m_ovf  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fp32_abs_max_stream.sv
module tb_fp32_abs_max_stream;

  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_data;
  logic [IDX_W-1:0] m_idx;
  logic             m_ovf;

  fp32_abs_max_stream #(.IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_ovf   (m_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
    logic             ovf;
  } result_t;

  result_t     exp_q[$];
  logic [31:0] frame_q[$];

  int checks = 0;
  int errors = 0;
  bit mr_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first element of greatest |x| over the whole frame.
  function automatic result_t model(input logic [31:0] fr[$]);
    result_t r;
    int best_pos = 0;
    for (int i = 1; i < fr.size(); i++) begin
      if (int'(fr[i][30:0]) > int'(fr[best_pos][30:0])) best_pos = i;
    end
    r.data = fr[best_pos];
    r.idx  = IDX_W'(best_pos % (1 << IDX_W));
    r.ovf  = (fr.size() > (1 << IDX_W));
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input logic last);
    int  n    = 0;
    bit  done = 0;
    bit  rdy;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!done) begin
      rdy = s_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        frame_q.push_back(d);
        if (last) begin
          exp_q.push_back(model(frame_q));
          frame_q.delete();
        end
      end else if (++n > 200) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: s_ready stuck at 0 expected 1 at %0t", $time);
        done = 1;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  always begin
    @(negedge clk);
    if (mr_rand) m_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard
  initial begin
    logic [31:0]      last_d = '0;
    logic [IDX_W-1:0] last_i = '0;
    logic             last_o = 1'b0;
    bit               hold_pend = 0;
    logic [31:0]      hold_d = '0;
    logic [IDX_W-1:0] hold_i = '0;
    logic             hold_o = 1'b0;
    result_t          e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        hold_pend = 0;
        last_d = '0;
        last_i = '0;
        last_o = 1'b0;
      end else begin
        if (hold_pend && m_valid) begin
          chk("hold_m_data", m_data, hold_d);
          chk("hold_m_idx", 32'(m_idx), 32'(hold_i));
          chk("hold_m_ovf", 32'(m_ovf), 32'(hold_o));
        end
        if (!m_valid) begin
          chk("idle_m_data", m_data, last_d);
          chk("idle_m_idx", 32'(m_idx), 32'(last_i));
          chk("idle_m_ovf", 32'(m_ovf), 32'(last_o));
        end else begin
          chk("hold_s_ready", 32'(s_ready), 32'd0);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h expected no result at %0t", m_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", m_data, e.data);
            chk("res_idx", 32'(m_idx), 32'(e.idx));
            chk("res_ovf", 32'(m_ovf), 32'(e.ovf));
          end
          last_d = m_data;
          last_i = m_idx;
          last_o = m_ovf;
        end
        hold_pend = m_valid && !m_ready;
        hold_d = m_data;
        hold_i = m_idx;
        hold_o = m_ovf;
      end
    end
  end

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending expected 0", exp_q.size());
    end
  endtask

  logic [31:0] pool[4] = '{32'h40A00000, 32'h3F800000, 32'h7F800000, 32'h00000000};

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_idx", 32'(m_idx), 32'd0);
    chk("rst_m_ovf", 32'(m_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(s_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("ready_after_edge", 32'(s_ready), 32'd1);
    @(negedge clk);

    // Basic frame, latency check
    m_ready = 1'b1;
    send(32'h3F800000, 1'b0);
    send(32'hC0400000, 1'b0);
    send(32'h40000000, 1'b1);
    #1;
    chk("latency_m_valid", 32'(m_valid), 32'd1);
    chk("latency_m_data", m_data, 32'hC0400000);
    @(negedge clk);

    // -0 single, then +0 restart; tie keeps first
    send(32'h80000000, 1'b1);
    send(32'h00000000, 1'b1);
    send(32'h40A00000, 1'b0);
    send(32'hC0A00000, 1'b1);

    // Overflow with IDX_W = 2, then a clean frame
    for (int i = 0; i < 4; i++) send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    send(32'h3F800000, 1'b1);
    drain();

    // Backpressure: inputs must be ignored while holding
    m_ready = 1'b0;
    send(32'h41000000, 1'b1);
    s_valid = 1'b1;
    s_data  = 32'h42000000;
    s_last  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("bp_s_ready", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_ready_after", 32'(s_ready), 32'd1);
    send(32'h42000000, 1'b1);
    drain();

    // Reset mid-frame discards the partial frame
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    rst_n = 1'b0;
    frame_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h7F800000, 1'b1);
    drain();

    // Randomized frames with random backpressure
    mr_rand = 1;
    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        logic [31:0] d;
        if ($urandom_range(0, 2) == 0)
          d = {1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)][30:0]};
        else
          d = $urandom;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send(d, (k == len - 1) ? 1'b1 : 1'b0);
      end
    end
    mr_rand = 0;
    @(negedge clk);
    m_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_abs_max_stream.md
FP32_ABS_MAX_STREAM -- requirements
Module: fp32_abs_max_stream

Interface
REQ-001 Parameter IDX_W, default 16: width of element index within a frame.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_valid  input  1  input element valid.
REQ-005 s_ready  output  1  block can accept input element.
REQ-006 s_data  input  32  IEEE-754 fp32 element.
REQ-007 s_last  input  1  element is final of frame.
REQ-008 m_valid  output  1  frame result valid.
REQ-009 m_ready  input  1  downstream accepts result.
REQ-010 m_data  output  32  original fp32 word (sign preserved) with largest magnitude in frame.
REQ-011 m_idx  output  IDX_W  zero-based position of m_data within frame.
REQ-012 m_ovf  output  1  frame length exceeded 2^IDX_W elements.

Function
REQ-013 Input transfer SHALL occur on a rising edge where s_valid and s_ready are both 1; output transfer where m_valid and m_ready are both 1.
REQ-014 Magnitude SHALL be bits [30:0] compared as an unsigned integer; sign bit ignored; no NaN/denormal special-casing (NaN ranks above infinity, +0 equals -0).
REQ-015 FSM SHALL have three states: IDLE (no element of current frame accepted), ACCUM (at least one accepted, no last yet), HOLD (result presented).
REQ-016 s_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD; m_valid SHALL be 1 only in HOLD.
REQ-017 In IDLE, an accepted element SHALL unconditionally load best value, best index = 0, element counter = 1; next state ACCUM, or HOLD if s_last = 1.
REQ-018 In ACCUM, an accepted element SHALL replace best value/index only when its magnitude is strictly greater than the stored magnitude; ties keep the earlier element.
REQ-019 Element counter SHALL increment per accepted element, wrapping modulo 2^IDX_W; index recorded for a replacement is the counter value before increment.
REQ-020 If an element is accepted while the counter has wrapped to 0 in ACCUM, an overflow flag SHALL set and remain set until the frame's result is consumed.
REQ-021 Accepting an element with s_last = 1 SHALL move to HOLD; m_valid SHALL assert on the following cycle (latency 1 cycle from last transfer) with the last element included in the comparison.
REQ-022 In HOLD, m_data, m_idx, m_ovf SHALL remain stable while m_valid = 1 and m_ready = 0.
REQ-023 On output transfer, FSM SHALL return to IDLE, clear overflow flag and counter; s_ready SHALL reassert the next cycle (no same-cycle bypass).
REQ-024 s_valid, s_data, s_last SHALL be ignored while s_ready = 0.
REQ-025 m_data, m_idx, m_ovf SHALL hold their last values in IDLE/ACCUM (they update only on entry to HOLD).

Reset
REQ-026 While rst_n = 0: FSM = IDLE, s_ready = 0, m_valid = 0, m_data = 0, m_idx = 0, m_ovf = 0, counter = 0, best value = 0.
REQ-027 s_ready SHALL assert on the first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result immediately; no output transfer for it.

Verification
REQ-029 Frame 0x3F800000 (1.0), 0xC0400000 (-3.0), 0x40000000 (2.0, last), m_ready = 1 -> one cycle after last: m_valid = 1, m_data = 0xC0400000, m_idx = 1, m_ovf = 0.
REQ-030 Single element 0x80000000 with s_last = 1 -> m_data = 0x80000000, m_idx = 0; then frame 0x00000000 (last) -> m_idx = 0 (tie keeps first, new frame restarts).
REQ-031 Tie: 0x40A00000 (5.0), 0xC0A00000 (-5.0, last) -> m_data = 0x40A00000, m_idx = 0.
REQ-032 Backpressure: m_ready = 0 for 10 cycles in HOLD with s_valid = 1 -> s_ready = 0, outputs stable, no input consumed; m_ready = 1 -> transfer, s_ready = 1 next cycle.
REQ-033 IDX_W = 2, frame of 5 elements with largest at position 4 -> m_ovf = 1, m_idx = 0 (wrapped); next frame m_ovf = 0.
REQ-034 rst_n pulsed low after two elements of a frame -> m_valid = 0, s_ready = 0 during reset; subsequent frame 0x7F800000 (last) -> m_data = 0x7F800000, m_idx = 0.
